comp_8bit_serial: RTL and testbench

COMP_8BIT_SERIAL -- requirements
Module: comp_8bit_serial

---
 rtl/comp_8bit_serial.sv | 116 +++++++++++
 tb/tb_comp_8bit_serial.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/comp_8bit_serial.sv
// Bit-serial unsigned 8-bit magnitude comparator, MSB first; result 1..8 cycles after start.
// No backpressure: start is ignored while busy, and results hold until the next accepted start.
module comp_8bit_serial (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       busy,
  output logic       done,
  output logic       a_gt_b,
  output logic       a_eq_b,
  output logic       a_lt_b
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPARE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [2:0] idx_q, idx_d;
  logic       gt_q, gt_d;
  logic       eq_q, eq_d;
  logic       lt_q, lt_d;

  logic       bit_a;
  logic       bit_b;
  logic       accept;

  always_comb begin
    bit_a  = a_q[idx_q];
    bit_b  = b_q[idx_q];
    accept = start && ((state_q == IDLE) || (state_q == DONE));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: state_d = start ? COMPARE : IDLE;
      COMPARE: begin
        // Stop at the first differing bit, or after bit 0 when all bits matched.
        if ((bit_a != bit_b) || (idx_q == 3'd0)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    idx_d = idx_q;
    gt_d  = gt_q;
    eq_d  = eq_q;
    lt_d  = lt_q;
    if (accept) begin
      a_d   = a;
      b_d   = b;
      idx_d = 3'd7;
      gt_d  = 1'b0;
      eq_d  = 1'b0;
      lt_d  = 1'b0;
    end else if (state_q == COMPARE) begin
      if (bit_a && !bit_b) begin
        gt_d = 1'b1;
      end else if (!bit_a && bit_b) begin
        lt_d = 1'b1;
      end else if (idx_q == 3'd0) begin
        eq_d = 1'b1;
      end else begin
        idx_d = idx_q - 3'd1;
      end
    end
  end

  // Operands and bit index are only meaningful after an accepted start, so they carry no reset.
  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    idx_q <= idx_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gt_q <= 1'b0;
      eq_q <= 1'b0;
      lt_q <= 1'b0;
    end else begin
      gt_q <= gt_d;
      eq_q <= eq_d;
      lt_q <= lt_d;
    end
  end

  always_comb begin
    busy   = (state_q == COMPARE);
    done   = (state_q == DONE);
    a_gt_b = gt_q;
    a_eq_b = eq_q;
    a_lt_b = lt_q;
  end

endmodule

// File: tb/tb_comp_8bit_serial.sv
// Randomized scoreboard bench for comp_8bit_serial against an arithmetic reference model.
module tb_comp_8bit_serial;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       busy;
  logic       done;
  logic       a_gt_b;
  logic       a_eq_b;
  logic       a_lt_b;

  comp_8bit_serial dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .a_gt_b (a_gt_b),
    .a_eq_b (a_eq_b),
    .a_lt_b (a_lt_b)
  );

  always #5 clk = ~clk;

  // Edge counter: after rising edge number e, cyc == e.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [2:0] flags;
    int         done_cyc;
    int         epoch;
  } exp_t;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  // Reference model state, written only by the stimulus process.
  int         epoch      = 0;
  int         next_free  = 0;
  int         win_lo     = -1000;
  int         win_hi     = -1000;
  int         flags_from = 0;
  logic [2:0] final_flags = 3'b000;
  logic       mon_en     = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_latency(input logic [7:0] x, input logic [7:0] y);
    int diff;
    diff = int'(x ^ y);
    if (diff == 0) return 8;
    return 8 - ($clog2(diff + 1) - 1);
  endfunction

  function automatic logic [2:0] ref_flags(input logic [7:0] x, input logic [7:0] y);
    return {x > y, x == y, x < y};
  endfunction

  task automatic step(input logic s, input logic [7:0] av, input logic [7:0] bv, input logic r);
    int lat;
    @(negedge clk);
    start = s;
    a     = av;
    b     = bv;
    rst   = r;
    @(posedge clk);
    #1;
    if (r) begin
      epoch++;
      next_free   = 0;
      win_lo      = -1000;
      win_hi      = -1000;
      final_flags = 3'b000;
      flags_from  = 0;
    end else if (s && (cyc >= next_free)) begin
      lat = ref_latency(av, bv);
      sb.push_back('{flags: ref_flags(av, bv), done_cyc: cyc + lat, epoch: epoch});
      win_lo      = cyc;
      win_hi      = cyc + lat;
      final_flags = ref_flags(av, bv);
      flags_from  = cyc + lat;
      next_free   = cyc + lat + 1;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), 8'($urandom), 1'b0);
  endtask

  task automatic op(input logic [7:0] av, input logic [7:0] bv);
    step(1'b1, av, bv, 1'b0);
    idle(10);
  endtask

  // Monitor: pops the scoreboard on done and checks busy/flag levels every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      while (sb.size() > 0 && (sb[0].epoch != epoch || sb[0].done_cyc < cyc)) begin
        e = sb.pop_front();
        if (e.epoch == epoch) begin
          n_chk++;
          n_fail++;
          $display("FAIL missed_done: no done by cycle %0d, required at %0d", cyc, e.done_cyc);
        end
      end
      check("busy", 32'(busy), 32'(cyc >= win_lo && cyc < win_hi));
      if (done) begin
        if (sb.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done: done high at cycle %0d with nothing pending", cyc);
        end else begin
          e = sb.pop_front();
          check("done_cycle", 32'(cyc), 32'(e.done_cyc));
          check("done_flags", 32'({a_gt_b, a_eq_b, a_lt_b}), 32'(e.flags));
        end
      end else begin
        check("flags_level", 32'({a_gt_b, a_eq_b, a_lt_b}),
              32'((cyc >= flags_from) ? final_flags : 3'b000));
      end
    end
  end

  initial begin
    logic [7:0] ra, rb;
    start = 1'b0;
    a     = 8'd0;
    b     = 8'd0;
    rst   = 1'b1;
    step(1'b0, 8'd0, 8'd0, 1'b1);
    step(1'b1, 8'd9, 8'd3, 1'b1);
    check("reset_outputs", 32'({busy, done, a_gt_b, a_eq_b, a_lt_b}), 32'd0);
    mon_en = 1'b1;

    op(8'd100, 8'd50);
    op(8'd25, 8'd75);
    op(8'd255, 8'd0);
    op(8'd0, 8'd255);
    op(8'd150, 8'd150);
    op(8'd0, 8'd0);
    op(8'd1, 8'd0);

    // A second start during COMPARE must be ignored.
    step(1'b1, 8'd150, 8'd150, 1'b0);
    step(1'b1, 8'd3, 8'd200, 1'b0);
    step(1'b1, 8'd200, 8'd3, 1'b0);
    idle(10);

    // Reset three cycles into an equal-operand comparison.
    step(1'b1, 8'd150, 8'd150, 1'b0);
    idle(2);
    step(1'b1, 8'd0, 8'd255, 1'b1);
    check("abort_outputs", 32'({busy, done, a_gt_b, a_eq_b, a_lt_b}), 32'd0);
    op(8'd1, 8'd0);

    // Start held high: back-to-back comparisons with no idle cycle.
    for (int i = 0; i < 12; i++) step(1'b1, 8'd255, 8'd0, 1'b0);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom);
      case ($urandom_range(3, 0))
        0:       rb = ra;
        1:       rb = ra ^ (8'd1 << $urandom_range(7, 0));
        default: rb = 8'($urandom);
      endcase
      step($urandom_range(9, 0) < 6, ra, rb, $urandom_range(99, 0) < 2);
    end
    idle(12);

    foreach (sb[i]) begin
      if (sb[i].epoch == epoch) begin
        n_chk++;
        n_fail++;
        $display("FAIL leftover: expected done at cycle %0d never seen", sb[i].done_cyc);
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
